uart_rx_cfg: RTL and testbench
==============================

# uart_rx_cfg

Parametrised UART receiver, successor to the fixed 8-bit receiver in the UART subsystem. Recovers frames of DATA_WIDTH data bits from an oversampled serial line, with runtime-selectable parity, one or two stop bits, 3-sample majority voting, and separate parity, stop and break error reporting. Sits between the RX pin and the RX data-sync/FIFO stage in the UART clock domain.

## Interface
- DATA_WIDTH, 8, data bits per frame (5..9), LSB first
- PRESCALE_W, 6, width of Prescale input
- CLK  in  1  UART oversampling clock
- RST  in  1  asynchronous reset, active-high
- RX_IN  in  1  serial line, idle high, already synchronous to CLK
- Prescale  in  PRESCALE_W  oversampling ratio P (CLK cycles per bit)
- PAR_EN  in  1  1 = parity bit present
- PAR_TYP  in  1  0 = even, 1 = odd
- STOP2  in  1  1 = two stop bits
- P_DATA  out  DATA_WIDTH  last good received word
- data_valid  out  1  one-cycle pulse, P_DATA updated
- par_err  out  1  one-cycle pulse, parity mismatch
- stp_err  out  1  one-cycle pulse, a stop bit sampled 0
- brk_det  out  1  one-cycle pulse, break frame

## Operation
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- Effective P: Prescale with bit 0 forced to 0; values below 6 treated as 6.
- PAR_EN, PAR_TYP, STOP2 and effective P captured at start detection; changes mid-frame ignored.
- IDLE: edge sampling RX_IN=0 is frame edge 0 -> START. Frame edge k belongs to bit k/P with edge_cnt = k mod P.
- Each bit: samples at edge_cnt P/2-1, P/2, P/2+1; bit value = majority, resolved at edge_cnt P/2+1.
- START: majority 1 -> IDLE at that edge, no outputs (glitch rejection); else continue.
- DATA: DATA_WIDTH bits shifted in LSB first. PARITY only if PAR_EN. STOP: 1 bit, or 2 if STOP2.
- Evaluation at edge_cnt P/2+1 of final stop bit: par_err = PAR_EN and (XOR of data ^ parity bit ^ PAR_TYP) != 0; stp_err = any stop bit 0; brk_det = stp_err and all data bits 0 and (parity bit 0 or !PAR_EN); data_valid = !par_err and !stp_err.
- P_DATA loaded only when data_valid; otherwise holds previous value.
- After evaluation: stp_err -> WAIT_HIGH (stays until an edge samples RX_IN=1, then IDLE); else -> IDLE directly.

## Timing
- Reset (async, any state, mid-frame included): state IDLE, counters 0, P_DATA=0, data_valid/par_err/stp_err/brk_det=0.
- N = 1 + DATA_WIDTH + PAR_EN + 1 + STOP2 bits. Flags registered at frame edge (N-1)*P + P/2+1; high for exactly one cycle after it.
- Same edge returns FSM to IDLE, so next start edge may be detected from frame edge (N-1)*P + P/2+2 (tolerates short stop bit, back-to-back frames).
- Glitch rejection latency: IDLE after frame edge P/2+1.
- Flags mutually consistent: data_valid never with par_err/stp_err; brk_det only with stp_err.
- 3-sample vote: any single corrupted sample per bit has no effect.

## Test plan
- P=16, DATA_WIDTH=8, PAR_EN=1, PAR_TYP=1, STOP2=0; frame data 0x55, parity 1, stop 1 -> data_valid one cycle after frame edge 169, P_DATA=0x55, no error flags.
- Same config, data 0x51, correct parity, stop 0, then line high -> stp_err pulse, data_valid 0, P_DATA stays 0x55; FSM in WAIT_HIGH until RX_IN=1.
- Same config, data 0x41, parity bit 0 -> par_err pulse only, P_DATA stays 0x55.
- RX_IN low 4 cycles then high, followed by valid 0xA3 frame -> no flags for glitch; 0xA3 received with data_valid.
- PAR_EN=0, RX_IN low 300 cycles then high -> stp_err and brk_det at frame edge 153, no second frame detected while low; next valid frame 0x3C received after line returns high.
- STOP2=1, P=8, two back-to-back 0xFF frames with one inverted sample at edge_cnt P/2 of bit 3; RST pulsed mid-third frame -> both 0xFF received, all outputs 0 immediately at RST, no flags for the aborted frame.

Source files
------------

// File: rtl/uart_rx_cfg_if.sv
// Purpose: serial-line, runtime-config and received-word signals of the UART receiver.
// Latency: none, wiring only.
// Backpressure: none; result flags are single-cycle pulses with no ready.
interface uart_rx_cfg_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
);
    logic                  RX_IN;
    logic [PRESCALE_W-1:0] Prescale;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  STOP2;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;
    logic                  brk_det;

    // Line driver / config owner side.
    modport master (
        output RX_IN, Prescale, PAR_EN, PAR_TYP, STOP2,
        input  P_DATA, data_valid, par_err, stp_err, brk_det
    );

    // Receiver side.
    modport slave (
        input  RX_IN, Prescale, PAR_EN, PAR_TYP, STOP2,
        output P_DATA, data_valid, par_err, stp_err, brk_det
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Purpose: oversampled UART receiver, DATA_WIDTH bits LSB first, optional parity, 1/2 stop, 3-sample vote.
// Latency: result flags one cycle after frame edge (N-1)*P + P/2+1 of the frame.
// Backpressure: none; consumer must accept data_valid/error pulses when they occur.
module uart_rx_cfg #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic          CLK,
    input  logic          RST,
    uart_rx_cfg_if.slave  rx
);
    localparam int BW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, WAIT_HIGH
    } state_t;

    state_t state, state_n;

    logic [PRESCALE_W-1:0] edge_cnt;
    logic [PRESCALE_W-1:0] cfg_p;
    logic                  cfg_par_en;
    logic                  cfg_par_typ;
    logic                  cfg_stop2;
    logic [BW-1:0]         bit_cnt;
    logic                  s0, s1;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_bit;
    logic                  stp_bad;

    logic [PRESCALE_W-1:0] p_even, p_eff, half;
    logic                  at_s0, at_s1, at_res, at_end;
    logic                  vote, last_data, last_stop;
    logic                  start_det, eval;
    logic                  par_err_c, stp_err_c, brk_c;

    // Odd ratios round down to even; very small ratios are clamped so the three
    // vote samples always fit inside one bit period.
    assign p_even = {rx.Prescale[PRESCALE_W-1:1], 1'b0};
    assign p_eff  = (p_even < PRESCALE_W'(6)) ? PRESCALE_W'(6) : p_even;
    assign half   = cfg_p >> 1;

    assign at_s0  = (edge_cnt == half - PRESCALE_W'(1));
    assign at_s1  = (edge_cnt == half);
    assign at_res = (edge_cnt == half + PRESCALE_W'(1));
    assign at_end = (edge_cnt == cfg_p - PRESCALE_W'(1));

    // Third sample is the live line value at the resolving edge.
    assign vote = (s0 & s1) | (s0 & rx.RX_IN) | (s1 & rx.RX_IN);

    assign last_data = (bit_cnt == BW'(DATA_WIDTH - 1));
    assign last_stop = (bit_cnt == (cfg_stop2 ? BW'(1) : BW'(0)));

    assign stp_err_c = stp_bad | ~vote;
    assign par_err_c = cfg_par_en & ((^shreg) ^ par_bit ^ cfg_par_typ);
    assign brk_c     = stp_err_c & ~(|shreg) & (~par_bit | ~cfg_par_en);

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state decode; bit-to-bit moves happen on the last edge of a bit period,
    // start rejection and final evaluation at the resolving edge.
    always_comb begin
        state_n   = state;
        start_det = 1'b0;
        eval      = 1'b0;
        case (state)
            IDLE: begin
                if (!rx.RX_IN) begin
                    state_n   = START;
                    start_det = 1'b1;
                end
            end
            START: begin
                if (at_res && vote)  state_n = IDLE;
                else if (at_end)     state_n = DATA;
            end
            DATA: begin
                if (at_end && last_data) state_n = cfg_par_en ? PARITY : STOP;
            end
            PARITY: begin
                if (at_end) state_n = STOP;
            end
            STOP: begin
                if (at_res && last_stop) begin
                    eval    = 1'b1;
                    state_n = stp_err_c ? WAIT_HIGH : IDLE;
                end
            end
            WAIT_HIGH: begin
                if (rx.RX_IN) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Counters, config capture, sampling, shifting and result registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            edge_cnt      <= '0;
            cfg_p         <= PRESCALE_W'(6);
            cfg_par_en    <= 1'b0;
            cfg_par_typ   <= 1'b0;
            cfg_stop2     <= 1'b0;
            bit_cnt       <= '0;
            s0            <= 1'b1;
            s1            <= 1'b1;
            shreg         <= '0;
            par_bit       <= 1'b0;
            stp_bad       <= 1'b0;
            rx.P_DATA     <= '0;
            rx.data_valid <= 1'b0;
            rx.par_err    <= 1'b0;
            rx.stp_err    <= 1'b0;
            rx.brk_det    <= 1'b0;
        end else begin
            rx.data_valid <= 1'b0;
            rx.par_err    <= 1'b0;
            rx.stp_err    <= 1'b0;
            rx.brk_det    <= 1'b0;

            // The start edge is edge 0 of bit 0, so the following edge is count 1.
            if (start_det)                                 edge_cnt <= PRESCALE_W'(1);
            else if (state_n == IDLE || state_n == WAIT_HIGH) edge_cnt <= '0;
            else if (at_end)                               edge_cnt <= '0;
            else                                           edge_cnt <= edge_cnt + PRESCALE_W'(1);

            if (start_det)   bit_cnt <= '0;
            else if (at_end) bit_cnt <= (state_n != state) ? '0 : bit_cnt + BW'(1);

            if (start_det) begin
                cfg_p       <= p_eff;
                cfg_par_en  <= rx.PAR_EN;
                cfg_par_typ <= rx.PAR_TYP;
                cfg_stop2   <= rx.STOP2;
                par_bit     <= 1'b0;
                stp_bad     <= 1'b0;
            end

            if (at_s0) s0 <= rx.RX_IN;
            if (at_s1) s1 <= rx.RX_IN;

            if (at_res) begin
                case (state)
                    DATA:    shreg   <= {vote, shreg[DATA_WIDTH-1:1]};
                    PARITY:  par_bit <= vote;
                    STOP:    if (!last_stop) stp_bad <= stp_bad | ~vote;
                    default: ;
                endcase
            end

            if (eval) begin
                rx.par_err    <= par_err_c;
                rx.stp_err    <= stp_err_c;
                rx.brk_det    <= brk_c;
                rx.data_valid <= ~par_err_c & ~stp_err_c;
                if (~par_err_c & ~stp_err_c) rx.P_DATA <= shreg;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Purpose: directed frame-level checks of uart_rx_cfg against hand-computed results.
// Latency: checks flag timing relative to the start edge of each frame.
// Backpressure: none; a negedge monitor counts every output pulse.
module tb_uart_rx_cfg;
    localparam int DW = 8;
    localparam int PW = 6;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    uart_rx_cfg_if #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) bus ();

    uart_rx_cfg #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
        .CLK (CLK),
        .RST (RST),
        .rx  (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Cycle counter: number of rising edges so far.
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge.
    int dv_n = 0, pe_n = 0, se_n = 0, bk_n = 0, bad_n = 0;
    int dv_at = 0, se_at = 0;
    always @(negedge CLK) begin
        if (bus.data_valid) begin dv_n <= dv_n + 1; dv_at <= cyc; end
        if (bus.par_err)    pe_n <= pe_n + 1;
        if (bus.stp_err)    begin se_n <= se_n + 1; se_at <= cyc; end
        if (bus.brk_det)    bk_n <= bk_n + 1;
        if ((bus.data_valid && (bus.par_err || bus.stp_err)) || (bus.brk_det && !bus.stp_err))
            bad_n <= bad_n + 1;
    end

    int b_dv, b_pe, b_se, b_bk;
    task automatic snap();
        @(negedge CLK);
        b_dv = dv_n; b_pe = pe_n; b_se = se_n; b_bk = bk_n;
    endtask

    // Value of cyc seen after the rising edge that is frame edge 0.
    int start_cyc = 0;

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            bus.RX_IN = 1'b1;
        end
    endtask

    // Drives one frame; the sample at (cbit, ccnt) is inverted (cbit=-1: none).
    task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                              input logic two_stop, input logic stop_v, input int p,
                              input int cbit, input int ccnt);
        logic [11:0] bits;
        int nb;
        bits = '0;
        for (int i = 0; i < 8; i++) bits[1+i] = d[i];
        nb = 9;
        if (pen) begin bits[nb] = pbit; nb++; end
        bits[nb] = stop_v; nb++;
        if (two_stop) begin bits[nb] = stop_v; nb++; end
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < p; c++) begin
                @(negedge CLK);
                if (b == 0 && c == 0) start_cyc = cyc + 1;
                bus.RX_IN = (b == cbit && c == ccnt) ? ~bits[b] : bits[b];
            end
        end
    endtask

    initial begin
        RST          = 1'b1;
        bus.RX_IN    = 1'b1;
        bus.Prescale = 6'd16;
        bus.PAR_EN   = 1'b1;
        bus.PAR_TYP  = 1'b1;
        bus.STOP2    = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_p_data", 32'(bus.P_DATA), 32'h0);
        chk("rst_dv", 32'(bus.data_valid), 32'h0);
        chk("rst_pe", 32'(bus.par_err), 32'h0);
        chk("rst_se", 32'(bus.stp_err), 32'h0);
        chk("rst_bk", 32'(bus.brk_det), 32'h0);
        RST = 1'b0;
        idle(5);

        // Good frame 0x55, odd parity bit 1.
        snap();
        send_frame(8'h55, 1'b1, 1'b1, 1'b0, 1'b1, 16, -1, -1);
        idle(10);
        chk("t1_dv_cnt", 32'(dv_n - b_dv), 32'd1);
        chk("t1_dv_time", 32'(dv_at - start_cyc), 32'd169);
        chk("t1_p_data", 32'(bus.P_DATA), 32'h55);
        chk("t1_errs", 32'((pe_n - b_pe) + (se_n - b_se) + (bk_n - b_bk)), 32'd0);

        // Stop bit low: stp_err only, word held.
        snap();
        send_frame(8'h51, 1'b1, 1'b0, 1'b0, 1'b0, 16, -1, -1);
        idle(10);
        chk("t2_se_cnt", 32'(se_n - b_se), 32'd1);
        chk("t2_se_time", 32'(se_at - start_cyc), 32'd169);
        chk("t2_dv_cnt", 32'(dv_n - b_dv), 32'd0);
        chk("t2_bk_pe", 32'((bk_n - b_bk) + (pe_n - b_pe)), 32'd0);
        chk("t2_p_data", 32'(bus.P_DATA), 32'h55);

        // Wrong parity: par_err only.
        snap();
        send_frame(8'h41, 1'b1, 1'b0, 1'b0, 1'b1, 16, -1, -1);
        idle(10);
        chk("t3_pe_cnt", 32'(pe_n - b_pe), 32'd1);
        chk("t3_dv_se_bk", 32'((dv_n - b_dv) + (se_n - b_se) + (bk_n - b_bk)), 32'd0);
        chk("t3_p_data", 32'(bus.P_DATA), 32'h55);

        // Short glitch is rejected, then 0xA3 (four ones, odd parity bit 1).
        snap();
        for (int i = 0; i < 4; i++) begin @(negedge CLK); bus.RX_IN = 1'b0; end
        idle(40);
        chk("t4_glitch_flags", 32'((dv_n - b_dv) + (pe_n - b_pe) + (se_n - b_se) + (bk_n - b_bk)), 32'd0);
        snap();
        send_frame(8'hA3, 1'b1, 1'b1, 1'b0, 1'b1, 16, -1, -1);
        idle(10);
        chk("t4_dv_cnt", 32'(dv_n - b_dv), 32'd1);
        chk("t4_p_data", 32'(bus.P_DATA), 32'hA3);

        // Break with parity off: one stp_err+brk_det, nothing more while low.
        bus.PAR_EN = 1'b0;
        snap();
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (i == 0) start_cyc = cyc + 1;
            bus.RX_IN = 1'b0;
        end
        idle(40);
        chk("t5_se_cnt", 32'(se_n - b_se), 32'd1);
        chk("t5_bk_cnt", 32'(bk_n - b_bk), 32'd1);
        chk("t5_se_time", 32'(se_at - start_cyc), 32'd153);
        chk("t5_dv_cnt", 32'(dv_n - b_dv), 32'd0);
        snap();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 16, -1, -1);
        idle(10);
        chk("t5_next_dv", 32'(dv_n - b_dv), 32'd1);
        chk("t5_next_p_data", 32'(bus.P_DATA), 32'h3C);
        chk("t5_next_errs", 32'((pe_n - b_pe) + (se_n - b_se)), 32'd0);

        // Two stop bits, P=8, back-to-back 0xFF with one corrupted middle sample.
        bus.PAR_EN   = 1'b1;
        bus.PAR_TYP  = 1'b1;
        bus.STOP2    = 1'b1;
        bus.Prescale = 6'd8;
        snap();
        send_frame(8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 8, 4, 4);
        send_frame(8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 8, 4, 4);
        idle(4);
        chk("t6_dv_cnt", 32'(dv_n - b_dv), 32'd2);
        chk("t6_p_data", 32'(bus.P_DATA), 32'hFF);
        chk("t6_errs", 32'((pe_n - b_pe) + (se_n - b_se) + (bk_n - b_bk)), 32'd0);

        // Third frame aborted by reset mid-data.
        snap();
        for (int i = 0; i < 8; i++)  begin @(negedge CLK); bus.RX_IN = 1'b0; end
        for (int i = 0; i < 20; i++) begin @(negedge CLK); bus.RX_IN = 1'b1; end
        #2 RST = 1'b1;
        #1;
        chk("t6_rst_p_data", 32'(bus.P_DATA), 32'h0);
        chk("t6_rst_flags", 32'({bus.data_valid, bus.par_err, bus.stp_err, bus.brk_det}), 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        idle(70);
        chk("t6_abort_flags", 32'((dv_n - b_dv) + (pe_n - b_pe) + (se_n - b_se) + (bk_n - b_bk)), 32'd0);
        chk("t6_abort_p_data", 32'(bus.P_DATA), 32'h0);

        chk("flag_consistency", 32'(bad_n), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
